// File: rtl/my_rx_pkg.sv
// Shared types for the receive deframer: FIFO entry layout and FSM state encoding.
package my_rx_pkg;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/my_rx_fifo.sv
// First-word fall-through FIFO of rx_entry_t; the head entry is always visible on rdata.
module my_rx_fifo
  import my_rx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  rx_entry_t wdata,
  input  logic      pop,
  output rx_entry_t rdata,
  output logic [AW:0] count,
  output logic      empty,
  output logic      full
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  rx_entry_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/my_rx_deframer.sv
// Receive deframer: hold register, commit FSM, frame/drop counters and sticky overflow
// in front of an FWFT FIFO that replays bytes with end-of-frame marking.
//
// state   | meaning
// IDLE    | no frame open
// ACTIVE  | current frame has committed bytes in the FIFO
// DISCARD | rest of the current frame is being dropped
module my_rx_deframer
  import my_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int AW = $clog2(DEPTH);

  rx_state_e        state_q, state_d;
  logic [7:0]       h_data_q, h_data_d;
  logic             h_vld_q, h_vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic      is_last;
  logic      push, drop_inc, frame_inc;
  rx_entry_t wr_entry, head;
  logic [AW:0] fifo_count, free;
  logic      fifo_empty, fifo_full;

  assign is_last = !in_valid;
  // Free space deliberately ignores a pop happening on the same edge.
  assign free    = (AW+1)'(DEPTH) - fifo_count;

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    wr_entry  = '0;
    drop_inc  = 1'b0;
    frame_inc = 1'b0;
    if (h_vld_q) begin
      if (state_q == DISCARD) begin
        drop_inc = 1'b1;
        if (is_last) state_d = IDLE;
      end else if (fifo_full) begin
        drop_inc = 1'b1;
        ovf_d    = 1'b1;
        state_d  = is_last ? IDLE : DISCARD;
      end else if (is_last) begin
        push      = 1'b1;
        wr_entry  = '{err: 1'b0, last: 1'b1, data: h_data_q};
        frame_inc = 1'b1;
        state_d   = IDLE;
      end else if (free == (AW+1)'(1)) begin
        // Last free slot: close the frame as truncated so the consumer sees an end.
        push      = 1'b1;
        wr_entry  = '{err: 1'b1, last: 1'b1, data: h_data_q};
        frame_inc = 1'b1;
        ovf_d     = 1'b1;
        state_d   = DISCARD;
      end else begin
        push     = 1'b1;
        wr_entry = '{err: 1'b0, last: 1'b0, data: h_data_q};
        state_d  = ACTIVE;
      end
    end
  end

  always_comb begin
    h_vld_d     = in_valid;
    h_data_d    = in_valid ? in_data : h_data_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (frame_inc) frame_cnt_d = frame_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_data_q    <= '0;
      h_vld_q     <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_data_q    <= h_data_d;
      h_vld_q     <= h_vld_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  my_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (out_ready),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Egress is forced to zero when empty so stale memory never shows on the port.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_last  = out_valid && head.last;
  assign out_err   = out_valid && head.err;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule
